// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and PLRU helpers for the 4-way cache access controller
package cache_pkg;

  localparam int NUM_WAYS = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    COMPARE,
    MISS_REQ,
    MISS_WAIT,
    RESP
  } state_e;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } op_e;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  // Tree walk: b0 picks the pair, b1/b2 pick within the pair.
  function automatic logic [1:0] plru_victim(input logic [2:0] plru);
    logic [1:0] way;
    if (!plru[0]) way = {1'b0, plru[1]};
    else          way = {1'b1, plru[2]};
    return way;
  endfunction

  function automatic logic [2:0] plru_update(input logic [2:0] plru, input logic [1:0] way);
    logic [2:0] nxt;
    nxt    = plru;
    nxt[0] = ~way[1];
    if (!way[1]) nxt[1] = ~way[0];
    else         nxt[2] = ~way[0];
    return nxt;
  endfunction

endpackage

// File: rtl/cache_tag_ram.sv
// rtl/cache_tag_ram.sv - per-set tags, valid bits and PLRU state with one sync read and one write port
module cache_tag_ram
  import cache_pkg::*;
#(
  parameter int INDEX_W = 14,
  parameter int TAG_W   = 16
) (
  input  logic                      clk,
  input  logic                      rd_en_i,
  input  logic [INDEX_W-1:0]        rd_idx_i,
  output logic [NUM_WAYS*TAG_W-1:0] rd_tags_o,
  output logic [NUM_WAYS-1:0]       rd_valid_o,
  output logic [2:0]                rd_plru_o,
  input  logic                      wr_en_i,
  input  logic [INDEX_W-1:0]        wr_idx_i,
  input  logic                      wr_tag_en_i,
  input  logic [1:0]                wr_way_i,
  input  logic [TAG_W-1:0]          wr_tag_i,
  input  logic [NUM_WAYS-1:0]       wr_valid_i,
  input  logic [2:0]                wr_plru_i
);
  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0]    tag_mem   [0:NUM_WAYS-1][0:SETS-1];
  logic [NUM_WAYS-1:0] valid_mem [0:SETS-1];
  logic [2:0]          plru_mem  [0:SETS-1];

  logic [NUM_WAYS*TAG_W-1:0] rd_tags_q;
  logic [NUM_WAYS-1:0]       rd_valid_q;
  logic [2:0]                rd_plru_q;

  // Read data holds until the next read so COMPARE and MISS_WAIT can reuse it.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        rd_tags_q[w*TAG_W +: TAG_W] <= tag_mem[w][rd_idx_i];
      end
      rd_valid_q <= valid_mem[rd_idx_i];
      rd_plru_q  <= plru_mem[rd_idx_i];
    end
    if (wr_en_i) begin
      valid_mem[wr_idx_i] <= wr_valid_i;
      plru_mem[wr_idx_i]  <= wr_plru_i;
      if (wr_tag_en_i) tag_mem[wr_way_i][wr_idx_i] <= wr_tag_i;
    end
  end

  assign rd_tags_o  = rd_tags_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_plru_o  = rd_plru_q;

endmodule

// File: rtl/cache_access_ctrl.sv
// rtl/cache_access_ctrl.sv - request sequencer for a 4-way tag store: lookup, PLRU victim, line fill, stats
module cache_access_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_fill_valid,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              busy
);
  localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
  localparam int LINE_W = ADDR_W - OFFSET_W;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [LINE_W-1:0]  line_q, line_d;
  op_e                op_q, op_d;
  logic [1:0]         way_q, way_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0] cur_idx;
  logic [TAG_W-1:0]   cur_tag;
  logic               unused_offset;
  assign cur_idx       = line_q[INDEX_W-1:0];
  assign cur_tag       = line_q[LINE_W-1 -: TAG_W];
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  logic                      rd_en, wr_en, wr_tag_en;
  logic [INDEX_W-1:0]        wr_idx;
  logic [NUM_WAYS*TAG_W-1:0] rd_tags;
  logic [NUM_WAYS-1:0]       rd_valid, wr_valid;
  logic [2:0]                rd_plru, wr_plru;

  cache_tag_ram #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tag_ram (
    .clk         (clk),
    .rd_en_i     (rd_en),
    .rd_idx_i    (req_addr[OFFSET_W +: INDEX_W]),
    .rd_tags_o   (rd_tags),
    .rd_valid_o  (rd_valid),
    .rd_plru_o   (rd_plru),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_tag_en_i (wr_tag_en),
    .wr_way_i    (way_q),
    .wr_tag_i    (cur_tag),
    .wr_valid_i  (wr_valid),
    .wr_plru_i   (wr_plru)
  );

  // Both scans run high-to-low so the lowest qualifying way is the one that sticks.
  logic       hit_any;
  logic [1:0] hit_way, victim_way;
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = 2'd0;
    victim_way = plru_victim(rd_plru);
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_tags[w*TAG_W +: TAG_W] == cur_tag)) begin
        hit_any = 1'b1;
        hit_way = 2'(w);
      end
      if (!rd_valid[w]) victim_way = 2'(w);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    line_d    = line_q;
    op_d      = op_q;
    way_d     = way_q;
    hit_d     = hit_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_tag_en = 1'b0;
    wr_idx    = cur_idx;
    wr_valid  = rd_valid;
    wr_plru   = rd_plru;
    case (state_q)
      INIT: begin
        wr_en    = 1'b1;
        wr_idx   = ptr_q;
        wr_valid = '0;
        wr_plru  = '0;
        ptr_d    = ptr_q + INDEX_W'(1);
        if (ptr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (req_valid) begin
          line_d  = req_addr[ADDR_W-1:OFFSET_W];
          op_d    = op_e'(req_we);
          rd_en   = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = COMPARE;
      COMPARE: begin
        if (hit_any) begin
          wr_en   = 1'b1;
          wr_plru = plru_update(rd_plru, hit_way);
          hit_d   = 1'b1;
          state_d = RESP;
        end else if (op_q == STORE) begin
          hit_d   = 1'b0;
          state_d = RESP;
        end else begin
          way_d   = victim_way;
          hit_d   = 1'b0;
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (mem_req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_fill_valid) begin
          wr_en     = 1'b1;
          wr_tag_en = 1'b1;
          wr_valid  = rd_valid | (4'b0001 << way_q);
          wr_plru   = plru_update(rd_plru, way_q);
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over a same-cycle event; counters stick at all-ones.
  logic hit_ev, miss_ev;
  always_comb begin
    hit_ev     = (state_q == COMPARE) && hit_any;
    miss_ev    = ((state_q == COMPARE) && !hit_any && (op_q == STORE)) ||
                 ((state_q == MISS_WAIT) && mem_fill_valid);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stat_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_ev && !(&hit_cnt_q))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      if (miss_ev && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      line_q     <= '0;
      op_q       <= LOAD;
      way_q      <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      line_q     <= line_d;
      op_q       <= op_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_hit      = hit_q;
  assign mem_req_valid = (state_q == MISS_REQ);
  assign mem_req_addr  = {line_q, {OFFSET_W{1'b0}}};
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_cache_access_ctrl.sv
// tb/tb_cache_access_ctrl.sv - self-checking bench for cache_access_ctrl
module tb_cache_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n, req_valid, req_ready, req_we, resp_valid, resp_hit;
  logic        mem_req_valid, mem_req_ready, mem_fill_valid, stat_clr, busy;
  logic [31:0] req_addr, mem_req_addr, hit_cnt, miss_cnt;

  logic        s_rst_n, s_req_valid, s_req_ready, s_req_we, s_resp_valid, s_resp_hit;
  logic        s_mem_req_valid, s_mem_req_ready, s_mem_fill_valid, s_stat_clr, s_busy;
  logic [31:0] s_req_addr, s_mem_req_addr;
  logic [3:0]  s_hit_cnt, s_miss_cnt;

  cache_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_fill_valid(mem_fill_valid), .stat_clr(stat_clr), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .busy(busy)
  );

  cache_access_ctrl #(.INDEX_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_we(s_req_we), .req_addr(s_req_addr), .resp_valid(s_resp_valid), .resp_hit(s_resp_hit),
    .mem_req_valid(s_mem_req_valid), .mem_req_ready(s_mem_req_ready), .mem_req_addr(s_mem_req_addr),
    .mem_fill_valid(s_mem_fill_valid), .stat_clr(s_stat_clr), .hit_cnt(s_hit_cnt),
    .miss_cnt(s_miss_cnt), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference cache: per-set tags/valids and a 3-bit tree, updated per transaction.
  logic [15:0] m_tag  [0:16383][0:3];
  logic        m_val  [0:16383][0:3];
  logic [2:0]  m_plru [0:16383];
  logic [31:0] m_hits, m_misses, exp_addr, last_mem_addr;
  logic        exp_hit, exp_mem;

  function automatic logic [2:0] touch(input logic [2:0] p, input int w);
    logic [2:0] r;
    r = p;
    r[0] = (w < 2);
    if (w < 2) r[1] = (w == 0);
    else       r[2] = (w == 2);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16384; i++) begin
      for (int w = 0; w < 4; w++) m_val[i][w] = 1'b0;
      m_plru[i] = 3'b000;
    end
    m_hits = 0; m_misses = 0; exp_hit = 1'b0; exp_mem = 1'b0; exp_addr = 0;
  endtask

  task automatic model_access(input logic we, input logic [31:0] a);
    int idx, hw, v;
    logic [15:0] tg;
    logic [2:0] p;
    idx = int'(a[15:2]);
    tg = a[31:16];
    hw = -1;
    for (int w = 0; w < 4; w++) if (hw < 0 && m_val[idx][w] && m_tag[idx][w] == tg) hw = w;
    exp_addr = {a[31:2], 2'b00};
    if (hw >= 0) begin
      exp_hit = 1'b1; exp_mem = 1'b0;
      m_plru[idx] = touch(m_plru[idx], hw);
      m_hits = m_hits + 1;
    end else begin
      exp_hit = 1'b0; exp_mem = !we;
      m_misses = m_misses + 1;
      if (!we) begin
        v = -1;
        for (int w = 0; w < 4; w++) if (v < 0 && !m_val[idx][w]) v = w;
        if (v < 0) begin
          p = m_plru[idx];
          v = p[0] ? (p[2] ? 3 : 2) : (p[1] ? 1 : 0);
        end
        m_tag[idx][v] = tg;
        m_val[idx][v] = 1'b1;
        m_plru[idx] = touch(m_plru[idx], v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_vs_ready", busy, !req_ready);
      if (mem_req_valid) begin
        check("mem_req_allowed", exp_mem, 1'b1);
        check("mem_req_addr", mem_req_addr, exp_addr);
      end
      if (resp_valid) begin
        check("resp_hit", resp_hit, exp_hit);
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, output int acc);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a;
    n = 0;
    while (!req_ready && n < 30000) begin @(posedge clk); #1; n++; end
    check("accept_ready", req_ready, 1'b1);
    model_access(we, a);
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a;
  endtask

  task automatic complete(input int acc, output logic got_hit);
    int n;
    if (exp_mem) begin
      n = 0;
      while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
      check("mem_req_seen", mem_req_valid, 1'b1);
      last_mem_addr = mem_req_addr;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 mem_req_ready = 1'b1;
      @(posedge clk); #1 mem_req_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 mem_fill_valid = 1'b1;
      @(posedge clk); #1 mem_fill_valid = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    check("resp_seen", resp_valid, 1'b1);
    got_hit = resp_hit;
    if (exp_hit) check("hit_latency", cyc - acc + 1, 3);
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, output logic got_hit);
    int acc;
    issue(we, a, acc);
    complete(acc, got_hit);
  endtask

  task automatic s_req(input logic [31:0] a, input logic clr, output logic got_hit);
    int n;
    @(posedge clk); #1;
    s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = a;
    n = 0;
    while (!s_req_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("s_accept_ready", s_req_ready, 1'b1);
    @(posedge clk); #1 s_req_valid = 1'b0;
    if (clr) begin
      @(posedge clk); #1 s_stat_clr = 1'b1;
      @(posedge clk); #1 s_stat_clr = 1'b0;
    end
    n = 0;
    while (!s_resp_valid && n < 40) begin
      @(negedge clk); n++;
      if (s_mem_req_valid) begin
        check("s_mem_req_addr", s_mem_req_addr, {a[31:2], 2'b00});
        @(posedge clk); #1 s_mem_fill_valid = 1'b1;
        @(posedge clk); #1 s_mem_fill_valid = 1'b0;
      end
    end
    check("s_resp_seen", s_resp_valid, 1'b1);
    got_hit = s_resp_hit;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    int n, acc;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 0;
    mem_req_ready = 1'b0; mem_fill_valid = 1'b0; stat_clr = 1'b0;
    s_rst_n = 1'b0; s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = 0;
    s_mem_req_ready = 1'b1; s_mem_fill_valid = 1'b0; s_stat_clr = 1'b0;
    model_reset();

    repeat (3) @(posedge clk); #1 s_rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_req_ready && n < 40) begin
      check("s_busy_during_init", s_busy, 1'b1);
      n++;
      @(negedge clk);
    end
    check("s_init_cycles", n, 16);
    check("s_hit_cnt_reset", s_hit_cnt, 4'd0);
    check("s_miss_cnt_reset", s_miss_cnt, 4'd0);
    s_req(32'h0000_0040, 1'b0, h);
    check("s_first_miss", h, 1'b0);
    check("s_miss_cnt_one", s_miss_cnt, 4'd1);
    for (int i = 0; i < 20; i++) s_req(32'h0000_0040, 1'b0, h);
    check("s_last_is_hit", h, 1'b1);
    check("s_hit_cnt_saturated", s_hit_cnt, 4'd15);
    s_req(32'h0000_0040, 1'b1, h);
    check("s_clear_wins", s_hit_cnt, 4'd0);
    s_req(32'h0000_0040, 1'b0, h);
    check("s_count_after_clear", s_hit_cnt, 4'd1);

    @(posedge clk); #1 rst_n = 1'b1;
    do_req(1'b0, 32'h0001_0006, h);
    check("cold_load_miss", h, 1'b0);
    check("cold_fill_addr", last_mem_addr, 32'h0001_0004);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    do_req(1'b0, 32'h0001_0006, h);
    check("repeat_load_hit", h, 1'b1);
    check("repeat_hit_cnt", hit_cnt, 32'd1);

    for (int t = 1; t <= 5; t++) begin
      do_req(1'b0, {16'(t), 16'h0040}, h);
      check("set_fill_miss", h, 1'b0);
    end
    do_req(1'b0, 32'h0003_0040, h);
    check("tag3_still_resident", h, 1'b1);
    do_req(1'b0, 32'h0001_0040, h);
    check("tag1_was_evicted", h, 1'b0);
    do_req(1'b0, 32'h0005_0040, h);
    check("tag5_resident", h, 1'b1);
    do_req(1'b0, 32'h0002_0040, h);
    check("tag2_was_evicted", h, 1'b0);

    do_req(1'b1, 32'h0002_0080, h);
    check("store_miss", h, 1'b0);
    check("store_miss_cnt", miss_cnt, 32'd9);
    do_req(1'b0, 32'h0002_0080, h);
    check("load_after_store_miss", h, 1'b0);
    do_req(1'b0, 32'h0002_0080, h);
    check("load_after_fill_hit", h, 1'b1);
    check("hit_cnt_running", hit_cnt, 32'd4);

    issue(1'b0, 32'h0003_0100, acc);
    n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    check("rst_mem_req_seen", mem_req_valid, 1'b1);
    @(posedge clk); #1 mem_req_ready = 1'b1;
    @(posedge clk); #1 mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 mem_fill_valid = 1'b1;
    @(posedge clk); #1 mem_fill_valid = 1'b0;
    do_req(1'b0, 32'h0003_0100, h);
    check("post_reset_load_miss", h, 1'b0);
    check("post_reset_miss_cnt", miss_cnt, 32'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
